decode_issue_stage: RTL and testbench

- RV32I decode stage directly upstream of RegisterBank.
- Accepts fetched instructions over a valid/ready handshake and drives rs1_addr/rs2_addr combinationally into RegisterBank.
- Captures rs1_data/rs2_data, with writeback bypass, plus decoded fields into the ID/EX pipeline register.
- Tracks in-flight destination registers with a busy-bit scoreboard and stalls on RAW and WAW hazards.

---
 rtl/decode_issue_stage_pkg.sv | 46 ++++
 rtl/decode_issue_stage_if.sv | 73 +++++++
 rtl/decode_issue_stage_imm_gen.sv | 35 +++
 rtl/decode_issue_stage.sv | 244 ++++++++++++++++++++++++
 tb/tb_decode_issue_stage.sv | 319 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/decode_issue_stage_pkg.sv
// Shared RV32I definitions for the decode/issue stage: opcode constants,
// the instruction-format enum and an opcode-to-format helper.
package rv32_pkg;

    // Default datapath and register-file geometry.
    localparam int DEFAULT_XLEN  = 32;
    localparam int DEFAULT_NREGS = 32;

    // RV32I base opcodes recognised by the decoder.
    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;

    // Instruction encoding formats; FMT_BAD marks an opcode outside the set above.
    typedef enum logic [2:0] {
        FMT_R,
        FMT_I,
        FMT_S,
        FMT_B,
        FMT_U,
        FMT_J,
        FMT_BAD
    } fmt_e;

    // Map an opcode onto its encoding format.
    function automatic fmt_e fmt_of(input logic [6:0] opcode);
        fmt_e f;
        case (opcode)
            OP:                 f = FMT_R;
            OP_IMM, LOAD, JALR: f = FMT_I;
            STORE:              f = FMT_S;
            BRANCH:             f = FMT_B;
            LUI, AUIPC:         f = FMT_U;
            JAL:                f = FMT_J;
            default:            f = FMT_BAD;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/decode_issue_stage_if.sv
// Bundle of the fetch-side handshake, register-bank read port, writeback
// snoop and ID/EX output of the decode/issue stage.
//
// Handshake rule (both if_* and ex_*): a transfer happens on a rising clk
// edge where valid and ready are both high. While valid is high and ready is
// low the producer keeps valid and its payload stable. ready is allowed to
// depend combinationally on valid and payload; valid never depends on ready.
interface decode_issue_stage_if #(
    parameter int XLEN  = rv32_pkg::DEFAULT_XLEN,
    parameter int NREGS = rv32_pkg::DEFAULT_NREGS
);

    // Fetch -> decode handshake.
    logic             if_valid;
    logic             if_ready;
    logic [31:0]      if_instr;
    logic [XLEN-1:0]  if_pc;

    // Register bank read port (combinational read).
    logic [4:0]       rs1_addr;
    logic [4:0]       rs2_addr;
    logic [XLEN-1:0]  rs1_data;
    logic [XLEN-1:0]  rs2_data;

    // Writeback snoop.
    logic             wb_valid;
    logic [4:0]       wb_rd;
    logic [XLEN-1:0]  wb_data;

    // Redirect from execute.
    logic             flush;

    // ID/EX pipeline register towards execute.
    logic             ex_valid;
    logic             ex_ready;
    logic [XLEN-1:0]  ex_pc;
    logic [XLEN-1:0]  ex_rs1_val;
    logic [XLEN-1:0]  ex_rs2_val;
    logic [XLEN-1:0]  ex_imm;
    logic [4:0]       ex_rd;
    logic [6:0]       ex_opcode;
    logic [2:0]       ex_funct3;
    logic             ex_funct7b5;
    logic             ex_illegal;

    // Scoreboard busy bits, exposed for observation.
    logic [NREGS-1:0] sb_busy;

    // The decode stage itself.
    modport slave (
        input  if_valid, if_instr, if_pc,
        input  rs1_data, rs2_data,
        input  wb_valid, wb_rd, wb_data,
        input  flush, ex_ready,
        output if_ready, rs1_addr, rs2_addr,
        output ex_valid, ex_pc, ex_rs1_val, ex_rs2_val, ex_imm,
        output ex_rd, ex_opcode, ex_funct3, ex_funct7b5, ex_illegal,
        output sb_busy
    );

    // The surrounding pipeline (fetch, register bank, execute, writeback).
    modport master (
        output if_valid, if_instr, if_pc,
        output rs1_data, rs2_data,
        output wb_valid, wb_rd, wb_data,
        output flush, ex_ready,
        input  if_ready, rs1_addr, rs2_addr,
        input  ex_valid, ex_pc, ex_rs1_val, ex_rs2_val, ex_imm,
        input  ex_rd, ex_opcode, ex_funct3, ex_funct7b5, ex_illegal,
        input  sb_busy
    );

endinterface

// File: rtl/decode_issue_stage_imm_gen.sv
// Immediate generator: assembles the RV32I immediate for the given format
// and sign-extends it to XLEN. R-format and unknown opcodes yield zero.
module imm_gen
    import rv32_pkg::*;
#(
    parameter int XLEN = DEFAULT_XLEN
) (
    input  logic [31:7]     instr_i,
    input  fmt_e            fmt_i,
    output logic [XLEN-1:0] imm_o
);

    logic [31:0] imm32;

    // Build the 32-bit immediate from the scattered instruction fields.
    always_comb begin
        imm32 = '0;
        case (fmt_i)
            FMT_I: imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
            FMT_S: imm32 = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
            FMT_B: imm32 = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                            instr_i[30:25], instr_i[11:8], 1'b0};
            FMT_U: imm32 = {instr_i[31:12], 12'b0};
            FMT_J: imm32 = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                            instr_i[20], instr_i[30:21], 1'b0};
            default: imm32 = '0;
        endcase
    end

    // Sign-extend (or keep) to the datapath width.
    always_comb begin
        imm_o = XLEN'($signed(imm32));
    end

endmodule

// File: rtl/decode_issue_stage.sv
// RV32I decode/issue stage. Decodes the fetched instruction, reads operands
// from the register bank (with writeback bypass), stalls on RAW/WAW hazards
// tracked by a busy-bit scoreboard, and loads the ID/EX pipeline register.
module decode_issue_stage
    import rv32_pkg::*;
#(
    parameter int XLEN  = DEFAULT_XLEN,
    parameter int NREGS = DEFAULT_NREGS
) (
    input logic                 clk,
    input logic                 rst_n,
    decode_issue_stage_if.slave bus
);

    // ------------------------------------------------------------------
    // Field extraction and decode
    // ------------------------------------------------------------------
    logic [31:0]     instr;
    logic [6:0]      opcode;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [2:0]      funct3;
    fmt_e            fmt;
    logic            legal;
    logic            uses_rs1;
    logic            uses_rs2;
    logic            writes_rd;
    logic [XLEN-1:0] imm;

    assign instr  = bus.if_instr;
    assign opcode = instr[6:0];
    assign rd     = instr[11:7];
    assign funct3 = instr[14:12];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];

    // Register bank addresses come straight from the instruction word.
    assign bus.rs1_addr = rs1;
    assign bus.rs2_addr = rs2;

    // Classify the instruction and work out which registers it touches.
    always_comb begin
        fmt       = fmt_of(opcode);
        legal     = (fmt != FMT_BAD);
        uses_rs1  = !((opcode == LUI) || (opcode == AUIPC) || (opcode == JAL));
        uses_rs2  = (fmt == FMT_R) || (fmt == FMT_S) || (fmt == FMT_B);
        writes_rd = legal && (fmt != FMT_S) && (fmt != FMT_B) && (rd != 5'd0);
    end

    imm_gen #(
        .XLEN (XLEN)
    ) u_imm_gen (
        .instr_i (instr[31:7]),
        .fmt_i   (fmt),
        .imm_o   (imm)
    );

    // ------------------------------------------------------------------
    // Scoreboard state and ID/EX register
    // ------------------------------------------------------------------
    logic [NREGS-1:0] busy_q, busy_d;

    logic             ex_valid_q,    ex_valid_d;
    logic             ex_owns_q,     ex_owns_d;   // held instr set a busy bit
    logic [XLEN-1:0]  ex_pc_q,       ex_pc_d;
    logic [XLEN-1:0]  ex_rs1_val_q,  ex_rs1_val_d;
    logic [XLEN-1:0]  ex_rs2_val_q,  ex_rs2_val_d;
    logic [XLEN-1:0]  ex_imm_q,      ex_imm_d;
    logic [4:0]       ex_rd_q,       ex_rd_d;
    logic [6:0]       ex_opcode_q,   ex_opcode_d;
    logic [2:0]       ex_funct3_q,   ex_funct3_d;
    logic             ex_funct7b5_q, ex_funct7b5_d;
    logic             ex_illegal_q,  ex_illegal_d;

    // ------------------------------------------------------------------
    // Hazard detection
    // ------------------------------------------------------------------
    logic [NREGS-1:0] wb_onehot;
    logic [NREGS-1:0] busy_eff;
    logic             hazard;
    logic             if_ready;
    logic             accept;

    // A register retiring this cycle is no longer a hazard; x0 never is.
    always_comb begin
        wb_onehot = '0;
        if (bus.wb_valid) begin
            wb_onehot[bus.wb_rd] = 1'b1;
        end
        busy_eff    = busy_q & ~wb_onehot;
        busy_eff[0] = 1'b0;
    end

    // Stall on any source that is still in flight (RAW) or a destination
    // already owned by an older instruction (WAW).
    always_comb begin
        hazard = bus.if_valid &&
                 ((uses_rs1  && busy_eff[rs1]) ||
                  (uses_rs2  && busy_eff[rs2]) ||
                  (writes_rd && busy_eff[rd]));
        if_ready = ((!ex_valid_q) || bus.ex_ready) && !hazard && !bus.flush;
        accept   = bus.if_valid && if_ready;
    end

    assign bus.if_ready = if_ready;

    // ------------------------------------------------------------------
    // Operand select with writeback bypass
    // ------------------------------------------------------------------
    function automatic logic [XLEN-1:0] pick_operand(
        input logic [4:0]      idx,
        input logic [XLEN-1:0] bank_val,
        input logic            wb_v,
        input logic [4:0]      wb_r,
        input logic [XLEN-1:0] wb_d
    );
        logic [XLEN-1:0] val;
        if (idx == 5'd0) begin
            val = '0;
        end else if (wb_v && (wb_r == idx)) begin
            val = wb_d;
        end else begin
            val = bank_val;
        end
        return val;
    endfunction

    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;

    // The register bank has not yet seen this cycle's writeback, so forward it.
    always_comb begin
        rs1_val = pick_operand(rs1, bus.rs1_data, bus.wb_valid, bus.wb_rd, bus.wb_data);
        rs2_val = pick_operand(rs2, bus.rs2_data, bus.wb_valid, bus.wb_rd, bus.wb_data);
    end

    // ------------------------------------------------------------------
    // Scoreboard update
    // ------------------------------------------------------------------
    // Clear on writeback or on flush of a held owner; a new owner set wins.
    always_comb begin
        busy_d = busy_q;
        if (bus.wb_valid && (bus.wb_rd != 5'd0)) begin
            busy_d[bus.wb_rd] = 1'b0;
        end
        if (bus.flush && ex_valid_q && !bus.ex_ready && ex_owns_q) begin
            busy_d[ex_rd_q] = 1'b0;
        end
        if (accept && writes_rd) begin
            busy_d[rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // Scoreboard register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign bus.sb_busy = busy_q;

    // ------------------------------------------------------------------
    // ID/EX register
    // ------------------------------------------------------------------
    // Load on accept, drain when execute consumes, otherwise hold stable.
    always_comb begin
        ex_valid_d    = ex_valid_q;
        ex_owns_d     = ex_owns_q;
        ex_pc_d       = ex_pc_q;
        ex_rs1_val_d  = ex_rs1_val_q;
        ex_rs2_val_d  = ex_rs2_val_q;
        ex_imm_d      = ex_imm_q;
        ex_rd_d       = ex_rd_q;
        ex_opcode_d   = ex_opcode_q;
        ex_funct3_d   = ex_funct3_q;
        ex_funct7b5_d = ex_funct7b5_q;
        ex_illegal_d  = ex_illegal_q;
        if (bus.flush) begin
            ex_valid_d = 1'b0;
            ex_owns_d  = 1'b0;
        end else if (accept) begin
            ex_valid_d    = 1'b1;
            ex_owns_d     = writes_rd;
            ex_pc_d       = bus.if_pc;
            ex_rs1_val_d  = rs1_val;
            ex_rs2_val_d  = rs2_val;
            ex_imm_d      = imm;
            ex_rd_d       = rd;
            ex_opcode_d   = opcode;
            ex_funct3_d   = funct3;
            ex_funct7b5_d = instr[30];
            ex_illegal_d  = !legal;
        end else if (bus.ex_ready) begin
            ex_valid_d = 1'b0;
            ex_owns_d  = 1'b0;
        end
    end

    // Pipeline register with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_valid_q    <= 1'b0;
            ex_owns_q     <= 1'b0;
            ex_pc_q       <= '0;
            ex_rs1_val_q  <= '0;
            ex_rs2_val_q  <= '0;
            ex_imm_q      <= '0;
            ex_rd_q       <= '0;
            ex_opcode_q   <= '0;
            ex_funct3_q   <= '0;
            ex_funct7b5_q <= 1'b0;
            ex_illegal_q  <= 1'b0;
        end else begin
            ex_valid_q    <= ex_valid_d;
            ex_owns_q     <= ex_owns_d;
            ex_pc_q       <= ex_pc_d;
            ex_rs1_val_q  <= ex_rs1_val_d;
            ex_rs2_val_q  <= ex_rs2_val_d;
            ex_imm_q      <= ex_imm_d;
            ex_rd_q       <= ex_rd_d;
            ex_opcode_q   <= ex_opcode_d;
            ex_funct3_q   <= ex_funct3_d;
            ex_funct7b5_q <= ex_funct7b5_d;
            ex_illegal_q  <= ex_illegal_d;
        end
    end

    assign bus.ex_valid    = ex_valid_q;
    assign bus.ex_pc       = ex_pc_q;
    assign bus.ex_rs1_val  = ex_rs1_val_q;
    assign bus.ex_rs2_val  = ex_rs2_val_q;
    assign bus.ex_imm      = ex_imm_q;
    assign bus.ex_rd       = ex_rd_q;
    assign bus.ex_opcode   = ex_opcode_q;
    assign bus.ex_funct3   = ex_funct3_q;
    assign bus.ex_funct7b5 = ex_funct7b5_q;
    assign bus.ex_illegal  = ex_illegal_q;

endmodule

// File: tb/tb_decode_issue_stage.sv
// Bench for decode_issue_stage: directed scenarios followed by random traffic,
// every cycle compared against a behavioural model of the stage.
module tb_decode_issue_stage;
    import rv32_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst_n;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    decode_issue_stage_if #(.XLEN(32), .NREGS(32)) bus ();

    decode_issue_stage dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Register bank stand-in with combinational read.
    logic [31:0] rf [32];
    assign bus.rs1_data = rf[bus.rs1_addr];
    assign bus.rs2_data = rf[bus.rs2_addr];

    int errors = 0;
    int checks = 0;

    // ---------------- reference model state ----------------
    logic [31:0] m_busy;
    bit          m_exv;
    bit          m_exown;
    logic [31:0] m_pc, m_r1, m_r2, m_imm;
    logic [4:0]  m_rd;
    logic [6:0]  m_opc;
    logic [2:0]  m_f3;
    logic        m_f7;
    logic        m_ill;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit opc_legal(input logic [6:0] opc);
        return opc == OP || opc == OP_IMM || opc == LOAD || opc == STORE ||
               opc == BRANCH || opc == JAL || opc == JALR || opc == LUI || opc == AUIPC;
    endfunction

    // Immediate value computed arithmetically from the bit weights.
    function automatic logic [31:0] ref_imm(input logic [31:0] ins);
        int v;
        v = 0;
        case (ins[6:0])
            OP_IMM, LOAD, JALR: begin
                v = int'(ins[31:20]);
                if (ins[31]) v -= 4096;
            end
            STORE: begin
                v = int'(ins[31:25]) * 32 + int'(ins[11:7]);
                if (ins[31]) v -= 4096;
            end
            BRANCH: begin
                v = int'(ins[7]) * 2048 + int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2;
                if (ins[31]) v -= 4096;
            end
            LUI, AUIPC: v = int'(ins & 32'hFFFF_F000);
            JAL: begin
                v = int'(ins[19:12]) * 4096 + int'(ins[20]) * 2048 + int'(ins[30:21]) * 2;
                if (ins[31]) v -= 1048576;
            end
            default: v = 0;
        endcase
        return 32'(v);
    endfunction

    function automatic bit in_flight(input logic [4:0] r, input bit wbv, input logic [4:0] wbrd);
        return (r != 0) && m_busy[r] && !(wbv && wbrd == r);
    endfunction

    function automatic logic [31:0] read_reg(input logic [4:0] r, input bit wbv,
                                             input logic [4:0] wbrd, input logic [31:0] wbd);
        if (r == 0) return 32'h0;
        if (wbv && wbrd == r) return wbd;
        return rf[r];
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] ins;
        logic [6:0]  opc;
        case ($urandom_range(0, 11))
            0: opc = OP;
            1: opc = OP_IMM;
            2: opc = LOAD;
            3: opc = STORE;
            4: opc = BRANCH;
            5: opc = JAL;
            6: opc = JALR;
            7: opc = LUI;
            8: opc = AUIPC;
            9: opc = 7'h7F;
            10: opc = 7'h00;
            default: opc = 7'h5B;
        endcase
        ins = $urandom();
        ins[6:0]   = opc;
        ins[11:7]  = 5'($urandom_range(0, 9));
        ins[19:15] = 5'($urandom_range(0, 9));
        ins[24:20] = 5'($urandom_range(0, 9));
        return ins;
    endfunction

    // ---------------- checks of registered outputs ----------------
    task automatic check_ex();
        chk("ex_valid", bus.ex_valid, m_exv);
        chk("sb_busy", bus.sb_busy, m_busy);
        if (m_exv) begin
            chk("ex_pc", bus.ex_pc, m_pc);
            chk("ex_rs1_val", bus.ex_rs1_val, m_r1);
            chk("ex_rs2_val", bus.ex_rs2_val, m_r2);
            chk("ex_imm", bus.ex_imm, m_imm);
            chk("ex_rd", bus.ex_rd, m_rd);
            chk("ex_opcode", bus.ex_opcode, m_opc);
            chk("ex_funct3", bus.ex_funct3, m_f3);
            chk("ex_funct7b5", bus.ex_funct7b5, m_f7);
            chk("ex_illegal", bus.ex_illegal, m_ill);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        rst_n          = 1'b0;
        bus.if_valid   = 1'b1;
        bus.if_instr   = 32'h0050_0093;
        bus.if_pc      = 32'h100;
        bus.wb_valid   = 1'b0;
        bus.wb_rd      = 5'd0;
        bus.wb_data    = 32'h0;
        bus.flush      = 1'b0;
        bus.ex_ready   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ex_valid", bus.ex_valid, 0);
        chk("rst_ex_pc", bus.ex_pc, 0);
        chk("rst_ex_rs1_val", bus.ex_rs1_val, 0);
        chk("rst_ex_rs2_val", bus.ex_rs2_val, 0);
        chk("rst_ex_imm", bus.ex_imm, 0);
        chk("rst_ex_rd", bus.ex_rd, 0);
        chk("rst_ex_opcode", bus.ex_opcode, 0);
        chk("rst_ex_funct3", bus.ex_funct3, 0);
        chk("rst_ex_funct7b5", bus.ex_funct7b5, 0);
        chk("rst_ex_illegal", bus.ex_illegal, 0);
        chk("rst_busy", bus.sb_busy, 0);
        m_busy  = '0;
        m_exv   = 1'b0;
        m_exown = 1'b0;
        rst_n   = 1'b1;
    endtask

    // One clock cycle: drive inputs, check combinational outputs at the
    // falling edge, advance the model, check registered outputs after the edge.
    task automatic cycle(input bit iv, input logic [31:0] ins, input logic [31:0] pc,
                         input bit wbv, input logic [4:0] wbrd, input logic [31:0] wbd,
                         input bit fl, input bit exr, output bit rdy_seen);
        logic [6:0]  opc;
        logic [4:0]  rd, r1, r2;
        bit          legal, ur1, ur2, wr, hz, rdy, acc;
        logic [31:0] v1, v2;
        bus.if_valid = iv;
        bus.if_instr = ins;
        bus.if_pc    = pc;
        bus.wb_valid = wbv;
        bus.wb_rd    = wbrd;
        bus.wb_data  = wbd;
        bus.flush    = fl;
        bus.ex_ready = exr;
        opc   = ins[6:0];
        rd    = ins[11:7];
        r1    = ins[19:15];
        r2    = ins[24:20];
        legal = opc_legal(opc);
        ur1   = !(opc == LUI || opc == AUIPC || opc == JAL);
        ur2   = (opc == OP || opc == STORE || opc == BRANCH);
        wr    = legal && opc != STORE && opc != BRANCH && rd != 0;
        hz    = iv && ((ur1 && in_flight(r1, wbv, wbrd)) ||
                       (ur2 && in_flight(r2, wbv, wbrd)) ||
                       (wr  && in_flight(rd, wbv, wbrd)));
        rdy   = (!m_exv || exr) && !hz && !fl;
        acc   = iv && rdy;
        v1    = read_reg(r1, wbv, wbrd, wbd);
        v2    = read_reg(r2, wbv, wbrd, wbd);

        @(negedge clk);
        chk("if_ready", bus.if_ready, rdy);
        chk("rs1_addr", bus.rs1_addr, r1);
        chk("rs2_addr", bus.rs2_addr, r2);
        rdy_seen = bus.if_ready;

        if (wbv && wbrd != 0) m_busy[wbrd] = 1'b0;
        if (fl && m_exv && !exr && m_exown) m_busy[m_rd] = 1'b0;
        if (acc && wr) m_busy[rd] = 1'b1;
        if (fl) begin
            m_exv   = 1'b0;
            m_exown = 1'b0;
        end else if (acc) begin
            m_exv   = 1'b1;
            m_exown = wr;
            m_pc    = pc;
            m_r1    = v1;
            m_r2    = v2;
            m_imm   = legal ? ref_imm(ins) : 32'h0;
            m_rd    = rd;
            m_opc   = opc;
            m_f3    = ins[14:12];
            m_f7    = ins[30];
            m_ill   = !legal;
        end else if (exr) begin
            m_exv   = 1'b0;
            m_exown = 1'b0;
        end

        @(posedge clk);
        #1;
        if (wbv && wbrd != 0) rf[wbrd] = wbd;
        check_ex();
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "timeout");
    end

    // ---------------- stimulus ----------------
    initial begin
        bit rdy;
        bit wbv;
        for (int i = 0; i < 32; i++) rf[i] = $urandom();

        // Reset with a valid instruction presented.
        do_reset();
        cycle(1, 32'h0050_0093, 32'h100, 0, 0, 0, 0, 1, rdy);   // ADDI x1,x0,5
        chk("ready_after_reset", rdy, 1);
        chk("addi_imm", bus.ex_imm, 5);
        chk("addi_rd", bus.ex_rd, 1);
        chk("addi_valid", bus.ex_valid, 1);
        chk("addi_busy1", bus.sb_busy[1], 1);

        // RAW stall on x1 until its writeback, then bypass.
        cycle(1, 32'h0010_8133, 32'h104, 0, 0, 0, 0, 1, rdy);   // ADD x2,x1,x1
        chk("raw_stall", rdy, 0);
        cycle(1, 32'h0010_8133, 32'h104, 1, 5'd1, 32'd5, 0, 1, rdy);
        chk("raw_release", rdy, 1);
        chk("raw_rs1", bus.ex_rs1_val, 5);
        chk("raw_rs2", bus.ex_rs2_val, 5);

        // Backpressure: hold for three cycles, then reload on the same edge.
        cycle(1, 32'h0070_0293, 32'h108, 0, 0, 0, 0, 1, rdy);   // ADDI x5,x0,7
        for (int k = 0; k < 3; k++) begin
            cycle(1, 32'h0090_0313, 32'h10C, 0, 0, 0, 0, 0, rdy); // ADDI x6,x0,9
            chk("bp_ready", rdy, 0);
            chk("bp_hold_imm", bus.ex_imm, 7);
            chk("bp_hold_rd", bus.ex_rd, 5);
        end
        cycle(1, 32'h0090_0313, 32'h10C, 0, 0, 0, 0, 1, rdy);
        chk("bp_release", rdy, 1);
        chk("bp_new_imm", bus.ex_imm, 9);
        chk("bp_new_rd", bus.ex_rd, 6);

        // Bypass of a same-cycle writeback, and x0 always reads zero.
        rf[3] = 32'h1234_5678;
        cycle(1, 32'h0001_8393, 32'h110, 1, 5'd3, 32'hDEAD_BEEF, 0, 1, rdy); // ADDI x7,x3,0
        chk("bypass_rs1", bus.ex_rs1_val, 32'hDEAD_BEEF);
        cycle(1, 32'h0010_0413, 32'h114, 1, 5'd0, 32'hFFFF_FFFF, 0, 1, rdy); // ADDI x8,x0,1
        chk("x0_zero", bus.ex_rs1_val, 0);

        // Flush of a held LUI releases its busy bit.
        cycle(1, 32'hBADC_0237, 32'h118, 0, 0, 0, 0, 1, rdy);  // LUI x4,0xBADC0
        cycle(0, 32'h0, 32'h0, 0, 0, 0, 0, 0, rdy);
        chk("flush_held_busy", bus.sb_busy[4], 1);
        chk("lui_imm", bus.ex_imm, 32'hBADC_0000);
        cycle(1, 32'h0002_0493, 32'h11C, 0, 0, 0, 1, 0, rdy);  // ADDI x9,x4,0 + flush
        chk("flush_ready", rdy, 0);
        chk("flush_valid", bus.ex_valid, 0);
        chk("flush_busy", bus.sb_busy[4], 0);
        cycle(1, 32'h0002_0493, 32'h11C, 0, 0, 0, 0, 1, rdy);
        chk("after_flush_ready", rdy, 1);
        chk("after_flush_rd", bus.ex_rd, 9);

        // Immediates and illegal opcode.
        cycle(1, 32'hFE00_2E23, 32'h120, 0, 0, 0, 0, 1, rdy);  // SW x0,-4(x0)
        chk("sw_imm", bus.ex_imm, 32'hFFFF_FFFC);
        cycle(1, 32'h0000_0463, 32'h124, 0, 0, 0, 0, 1, rdy);  // BEQ x0,x0,+8
        chk("beq_imm", bus.ex_imm, 8);
        cycle(1, 32'h0000_057F, 32'h128, 0, 0, 0, 0, 1, rdy);  // opcode 0x7F, rd=x10
        chk("ill_flag", bus.ex_illegal, 1);
        chk("ill_imm", bus.ex_imm, 0);
        chk("ill_busy", bus.sb_busy[10], 0);

        // Random traffic with a reset in the middle.
        for (int n = 0; n < 600; n++) begin
            if (n == 300) do_reset();
            wbv = ($urandom_range(0, 1) == 1);
            cycle($urandom_range(0, 3) != 0, rand_instr(), $urandom(),
                  wbv, 5'($urandom_range(0, 15)), $urandom(),
                  $urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0, rdy);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
